instr_prefetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the decode stage.
- Generates sequential fetch addresses and runs a req/ack handshake to variable-latency instruction memory.
- Buffers up to DEPTH fetched instructions with their PCs and presents the head to decode.
- Honours decode stall, and flushes and refetches on a redirect (branch/jump/return kill).

---
 rtl/instr_prefetch_queue_pkg.sv | 20 ++
 rtl/instr_prefetch_queue_fifo.sv | 63 ++++++
 rtl/instr_prefetch_queue.sv | 104 ++++++++++
 tb/tb_instr_prefetch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch front end.
// Imported by the queue top and its fetch FIFO.
package instr_prefetch_queue_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// Circular buffer of fetched {instr, pc} entries.
// Pointers carry one extra bit so full and empty are distinguishable.
module fetch_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [PC_W-1:0]    push_pc,
  input  logic               pop,
  output logic [INSTR_W-1:0] head_instr,
  output logic [PC_W-1:0]    head_pc,
  output logic               empty,
  output logic               full,
  output logic [CW-1:0]      count
);

  fetch_entry_t mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;

  assign head_instr = mem[rd_ptr[AW-1:0]].instr;
  assign head_pc    = mem[rd_ptr[AW-1:0]].pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= '{instr: push_instr, pc: push_pc};
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch front end: sequential PC generation, one-deep imem handshake,
// prefetch buffering and redirect flush feeding the decode stage.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [PC_W-1:0]  PC_STEP  = 16'd1,
  parameter logic [PC_W-1:0]  RESET_PC = 16'h0000,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_npc,
  output logic [CW-1:0]      count
);

  state_t state_q;
  state_t state_d;

  logic [PC_W-1:0]    fetch_pc_q;
  logic [PC_W-1:0]    req_addr_q;
  logic               fetch_en_q;
  logic               push;
  logic               pop;
  logic               empty;
  logic               full;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_instr(imem_rdata),
    .push_pc   (imem_addr),
    .pop       (pop),
    .head_instr(head_instr),
    .head_pc   (head_pc),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  // A stale request keeps its original address while fetch_pc moves on.
  assign imem_addr = (state_q == S_FLUSH) ? req_addr_q : fetch_pc_q;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        imem_req = fetch_en_q && !full;
        push     = imem_req && imem_ack && !redirect_valid;
      end
      S_FLUSH: begin
        imem_req = 1'b1;
        if (imem_ack)
          state_d = S_RUN;
      end
    endcase
    if (redirect_valid)
      state_d = (imem_req && !imem_ack) ? S_FLUSH : S_RUN;
  end

  assign pop = out_valid && !stall && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      fetch_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_en_q <= 1'b1;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        req_addr_q <= imem_addr;
      end else if (push) begin
        fetch_pc_q <= fetch_pc_q + PC_STEP;
      end
    end
  end

  assign out_valid = !empty;
  assign out_instr = out_valid ? head_instr : NOP_INSTR;
  assign out_pc    = out_valid ? head_pc : '0;
  assign out_npc   = out_valid ? head_pc + PC_STEP : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a simple imem responder.
// Inputs change and outputs are checked on the falling clock edge.
module tb_instr_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_npc;
  logic [2:0]  count;

  logic mem_auto;
  logic ack_manual;
  logic held;

  int n_cmp;
  int n_bad;

  instr_prefetch_queue #(
    .DEPTH   (4),
    .PC_STEP (16'd1),
    .RESET_PC(16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_npc       (out_npc),
    .count         (count)
  );

  assign imem_ack   = mem_auto ? imem_req : ack_manual;
  assign imem_rdata = 16'hA000 + imem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    mem_auto       = 1'b0;
    ack_manual     = 1'b0;
    held           = 1'b1;

    repeat (2) @(posedge clk);
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_npc", out_npc, 0);
    chk("rst_count", count, 0);

    // streaming, zero-wait memory
    mem_auto = 1'b1;
    reset    = 1'b0;
    step();
    chk("st_req0", imem_req, 1);
    chk("st_addr0", imem_addr, 16'h0000);
    chk("st_valid0", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("st_addr", imem_addr, i + 1);
      chk("st_valid", out_valid, 1);
      chk("st_pc", out_pc, i);
      chk("st_instr", out_instr, 16'hA000 + i);
      chk("st_npc", out_npc, i + 1);
      chk("st_count", count, 1);
    end

    // backpressure: head 5 held, queue fills with 5..8
    stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_pc !== 16'd5) held = 1'b0;
    end
    chk("bp_count", count, 4);
    chk("bp_req", imem_req, 0);
    chk("bp_hold", held, 1);
    stall = 1'b0;
    step();
    chk("bp_pc6", out_pc, 6);
    chk("bp_cnt3", count, 3);
    chk("bp_req1", imem_req, 1);
    chk("bp_addr9", imem_addr, 9);
    for (int i = 7; i < 11; i++) begin
      step();
      chk("bp_drain_v", out_valid, 1);
      chk("bp_drain_pc", out_pc, i);
    end

    // redirect while request at addr 5 waits
    reset    = 1'b1;
    mem_auto = 1'b0;
    step();
    reset = 1'b0;
    chk("rd_idle", imem_req, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0005;
    step();
    redirect_valid = 1'b0;
    chk("rd_req5", imem_req, 1);
    chk("rd_addr5", imem_addr, 16'h0005);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    chk("fl_req", imem_req, 1);
    chk("fl_addr", imem_addr, 16'h0005);
    chk("fl_valid", out_valid, 0);
    step();
    chk("fl_addr2", imem_addr, 16'h0005);
    ack_manual = 1'b1;
    step();
    ack_manual = 1'b0;
    chk("fl_new_req", imem_req, 1);
    chk("fl_new_addr", imem_addr, 16'h0040);
    chk("fl_dropped", count, 0);
    mem_auto = 1'b1;
    step();
    chk("fl_out_v", out_valid, 1);
    chk("fl_out_pc", out_pc, 16'h0040);
    chk("fl_out_in", out_instr, 16'hA040);

    // redirect coinciding with an ack of addr 0x41
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    step();
    redirect_valid = 1'b0;
    chk("ra_valid", out_valid, 0);
    chk("ra_instr", out_instr, 0);
    chk("ra_addr", imem_addr, 16'h0100);
    step();
    chk("ra_out_v", out_valid, 1);
    chk("ra_out_pc", out_pc, 16'h0100);

    // wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    chk("wr_addr", imem_addr, 16'hFFFF);
    step();
    chk("wr_pc", out_pc, 16'hFFFF);
    chk("wr_npc", out_npc, 16'h0000);
    chk("wr_instr", out_instr, 16'h9FFF);
    chk("wr_addr0", imem_addr, 16'h0000);
    step();
    chk("wr_pc0", out_pc, 16'h0000);
    chk("wr_npc1", out_npc, 16'h0001);
    step();
    chk("wr_pc1", out_pc, 16'h0001);

    // reset mid-request with 2 entries queued
    stall = 1'b1;
    step();
    chk("mr_cnt2", count, 2);
    mem_auto   = 1'b0;
    ack_manual = 1'b0;
    step();
    chk("mr_req", imem_req, 1);
    chk("mr_addr", imem_addr, 16'h0003);
    #2 reset = 1'b1;
    #1;
    chk("mr_async_cnt", count, 0);
    chk("mr_async_v", out_valid, 0);
    chk("mr_async_req", imem_req, 0);
    ack_manual = 1'b1;
    stall      = 1'b0;
    step();
    reset = 1'b0;
    step();
    ack_manual = 1'b0;
    chk("mr_late_cnt", count, 0);
    chk("mr_late_v", out_valid, 0);
    chk("mr_req1", imem_req, 1);
    chk("mr_addr0", imem_addr, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
